// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, latched frame config,
// and the data-bit-count decode.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  typedef struct packed {
    logic [1:0] dbits;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } rx_cfg_t;

  localparam int DBITS_MIN = 5;
  localparam int MAX_DBITS = 8;

  function automatic logic [3:0] nbits(input logic [1:0] dbits);
    return 4'(DBITS_MIN) + {2'b00, dbits};
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchroniser, per-bit tick counter and bit strobe; 3-tick majority vote when
// UART_RX_MAJORITY_EN is defined (strobe then lands one tick after the centre tick).
module uart_rx_sampler #(
  parameter int OSR     = 16,
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_tick,
  input  logic rx,
  input  logic idle,
  input  logic in_start,
  output logic rxs,
  output logic bit_stb,
  output logic bit_val
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] MID  = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);

  logic [SYNC_FF-1:0] sync_q;
  logic [CW-1:0]      tcnt;
  logic               centre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_FF-2:0], rx};
  end

  assign rxs = sync_q[SYNC_FF-1];

  // START re-references the counter at its centre so later bits land on LAST
  assign centre = !idle && (in_start ? (tcnt == MID) : (tcnt == LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (idle) begin
      tcnt <= '0;
    end else if (rx_tick) begin
      if (centre || tcnt == LAST) tcnt <= '0;
      else                        tcnt <= tcnt + CW'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  logic       pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
      pend_q <= 1'b0;
    end else if (rx_tick) begin
      hist_q <= {hist_q[0], rxs};
      pend_q <= centre;
    end
  end

  assign bit_stb = rx_tick && pend_q;
  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign bit_stb = rx_tick && centre;
  assign bit_val = rxs;
`endif

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with error/break/overrun detection and a valid/ready holding
// register; rx_valid_o rises 1 clk after the last stop sample (UART_RX_MAJORITY_EN: 3-tick vote).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OSR     = 16,
  parameter int DATA_W  = 32,
  parameter int SYNC_FF = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_tick,
  input  logic [1:0]        data_bit_num_i,
  input  logic              parity_en_i,
  input  logic              parity_type_i,
  input  logic              stop_bit_num_i,
  input  logic              rx,
  input  logic              rx_ready_i,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              parity_error_o,
  output logic              frame_error_o,
  output logic              break_o,
  output logic              overrun_o,
  output logic              rts_n
);

  rx_state_e              state;
  rx_cfg_t                cfg_q;
  logic [MAX_DBITS-1:0]   data_q;
  logic [2:0]             bcnt;
  logic                   par_q, perr_q, stop0_q, stop_cnt;
  logic                   rxs, bit_stb, bit_val;

  logic                   last_data, par_exp, last_stop, first_stop;
  logic                   brk, ferr, xfer, load, valid_d;
  logic [DATA_W-1:0]      word;

  uart_rx_sampler #(.OSR(OSR), .SYNC_FF(SYNC_FF)) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_tick  (rx_tick),
    .rx       (rx),
    .idle     (state == IDLE),
    .in_start (state == START),
    .rxs      (rxs),
    .bit_stb  (bit_stb),
    .bit_val  (bit_val)
  );

  always_comb begin
    last_data  = ({1'b0, bcnt} == nbits(cfg_q.dbits) - 4'd1);
    par_exp    = cfg_q.par_odd ? ~^data_q : ^data_q;
    last_stop  = bit_stb && (state == STOP) && (!cfg_q.stop2 || stop_cnt);
    first_stop = cfg_q.stop2 ? stop0_q : bit_val;
    brk        = (data_q == '0) && (!cfg_q.par_en || !par_q) && !first_stop;
    ferr       = brk || !bit_val || (cfg_q.stop2 && !stop0_q);
    xfer       = rx_valid_o && rx_ready_i;
    load       = last_stop && (!rx_valid_o || rx_ready_i);
    valid_d    = load ? 1'b1 : (xfer ? 1'b0 : rx_valid_o);
    word       = '0;
    word[MAX_DBITS-1:0] = data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cfg_q    <= '0;
      data_q   <= '0;
      bcnt     <= '0;
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
      stop0_q  <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cfg_q    <= '{dbits: data_bit_num_i, par_en: parity_en_i,
                        par_odd: parity_type_i, stop2: stop_bit_num_i};
          data_q   <= '0;
          bcnt     <= '0;
          par_q    <= 1'b0;
          perr_q   <= 1'b0;
          stop0_q  <= 1'b0;
          stop_cnt <= 1'b0;
          if (rx_tick && !rxs) state <= START;
        end
        START: if (bit_stb) state <= bit_val ? IDLE : DATA;
        DATA: if (bit_stb) begin
          data_q[bcnt] <= bit_val;
          bcnt         <= bcnt + 3'd1;
          if (last_data) state <= cfg_q.par_en ? PARITY : STOP;
        end
        PARITY: if (bit_stb) begin
          par_q  <= bit_val;
          perr_q <= (bit_val != par_exp);
          state  <= STOP;
        end
        STOP: if (bit_stb) begin
          // leave on the stop centre so a back-to-back start edge is not missed
          if (last_stop) begin
            state <= IDLE;
          end else begin
            stop0_q  <= bit_val;
            stop_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_o     <= 1'b0;
      rts_n          <= 1'b1;
      rx_data_o      <= '0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
      break_o        <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      rx_valid_o <= valid_d;
      rts_n      <= valid_d;
      if (load) begin
        rx_data_o      <= word;
        parity_error_o <= perr_q;
        frame_error_o  <= ferr;
        break_o        <= brk;
      end
      if (last_stop && !load) overrun_o <= 1'b1;
      else if (xfer)          overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: OSR=16, one rx_tick every 2 clk, 32 clk per bit.
module tb_uart_rx_os;

  localparam int OSR      = 16;
  localparam int DATA_W   = 32;
  localparam int BIT_CLKS = OSR * 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_tick = 1'b0;
  logic [1:0]        data_bit_num = 2'd3;
  logic              parity_en = 1'b0;
  logic              parity_type = 1'b0;
  logic              stop_bit_num = 1'b0;
  logic              rx = 1'b1;
  logic              rx_ready = 1'b0;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              parity_error, frame_error, brk, overrun, rts_n;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_os #(.OSR(OSR), .DATA_W(DATA_W), .SYNC_FF(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_tick        (rx_tick),
    .data_bit_num_i (data_bit_num),
    .parity_en_i    (parity_en),
    .parity_type_i  (parity_type),
    .stop_bit_num_i (stop_bit_num),
    .rx             (rx),
    .rx_ready_i     (rx_ready),
    .rx_valid_o     (rx_valid),
    .rx_data_o      (rx_data),
    .parity_error_o (parity_error),
    .frame_error_o  (frame_error),
    .break_o        (brk),
    .overrun_o      (overrun),
    .rts_n          (rts_n)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 rx_tick = ~rx_tick;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_bit(input logic b, input bit glitch);
    rx = b;
    if (glitch) begin
      clks(16);
      rx = ~b;
      clks(2);
      rx = b;
      clks(BIT_CLKS - 18);
    end else begin
      clks(BIT_CLKS);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pe,
                            input logic pbit, input int ns, input int gl);
    line_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) line_bit(d[i], i == gl);
    if (pe) line_bit(pbit, 1'b0);
    for (int i = 0; i < ns; i++) line_bit(1'b1, 1'b0);
  endtask

  task automatic ready_pulse();
    rx_ready = 1'b1;
    clks(1);
    rx_ready = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic pe,
                          input logic fe, input logic bk, input logic ov);
    chk({tag, ".valid"}, {31'd0, rx_valid}, 32'd1);
    chk({tag, ".data"}, rx_data, d);
    chk({tag, ".perr"}, {31'd0, parity_error}, {31'd0, pe});
    chk({tag, ".ferr"}, {31'd0, frame_error}, {31'd0, fe});
    chk({tag, ".brk"}, {31'd0, brk}, {31'd0, bk});
    chk({tag, ".ovr"}, {31'd0, overrun}, {31'd0, ov});
    chk({tag, ".rts_n"}, {31'd0, rts_n}, 32'd1);
  endtask

  task automatic chk_released(input string tag);
    chk({tag, ".valid0"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, ".rts_n0"}, {31'd0, rts_n}, 32'd0);
    chk({tag, ".ovr0"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    // reset state
    clks(3);
    chk("rst.valid", {31'd0, rx_valid}, 32'd0);
    chk("rst.data", rx_data, 32'd0);
    chk("rst.flags", {28'd0, parity_error, frame_error, brk, overrun}, 32'd0);
    chk("rst.rts_n", {31'd0, rts_n}, 32'd1);
    rst_n = 1'b1;
    chk("rel.rts_n_before_edge", {31'd0, rts_n}, 32'd1);
    clks(1);
    chk("rel.rts_n_after_edge", {31'd0, rts_n}, 32'd0);
    clks(BIT_CLKS);

    // 1: 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, -1);
    chk_word("t1", 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    ready_pulse();
    chk_released("t1");

    // 2: 7E2 0x55 (four ones -> even parity bit 0), sent with parity bit 1
    data_bit_num = 2'd2; parity_en = 1'b1; parity_type = 1'b0; stop_bit_num = 1'b1;
    clks(4);
    send_frame(8'h55, 7, 1'b1, 1'b1, 2, -1);
    chk_word("t2", 32'h0000_0055, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_pulse();
    chk_released("t2");

    // 3: 6-tick low pulse is a false start, then 0x3C 8N1
    data_bit_num = 2'd3; parity_en = 1'b0; stop_bit_num = 1'b0;
    clks(4);
    rx = 1'b0;
    clks(12);
    rx = 1'b1;
    clks(2 * BIT_CLKS);
    chk("t3.no_valid", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, -1);
    chk_word("t3", 32'h0000_003C, 1'b0, 1'b0, 1'b0, 1'b0);
    ready_pulse();
    chk_released("t3");

    // 4: line low for 2 frame times: break word held, later break frames dropped
    rx = 1'b0;
    clks(20 * BIT_CLKS);
    rx = 1'b1;
    chk_word("t4", 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    clks(12 * BIT_CLKS);
    ready_pulse();
    chk_released("t4");

    // 5: two frames without ready -> first held, overrun
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, -1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, -1);
    chk_word("t5", 32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b1);
    ready_pulse();
    chk_released("t5");

    // 6: reset in the middle of a data phase, then 0x81
    line_bit(1'b0, 1'b0);
    line_bit(1'b1, 1'b0);
    line_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    clks(1);
    chk("t6.rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("t6.rst_rts_n", {31'd0, rts_n}, 32'd1);
    rx = 1'b1;
    clks(2);
    rst_n = 1'b1;
    clks(2 * BIT_CLKS);
    chk("t6.no_partial", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, -1);
    chk_word("t6", 32'h0000_0081, 1'b0, 1'b0, 1'b0, 1'b0);
    ready_pulse();
    chk_released("t6");

`ifdef UART_RX_MAJORITY_EN
    // one-tick glitch near bit 0 centre is voted out
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 0);
    chk_word("t6g", 32'h0000_0081, 1'b0, 1'b0, 1'b0, 1'b0);
    ready_pulse();
    chk_released("t6g");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
